// File: rtl/vproc_spec_queue_if.sv
// Decoder-to-dispatch handshake bundle for the speculative instruction queue.
// master drives enqueue, commit/kill and dequeue-ready; slave is the queue itself.
interface vproc_spec_queue_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 3
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              enq_valid_i;
  logic              enq_ready_o;
  logic [ID_W-1:0]   enq_id_i;
  logic              enq_committed_i;
  logic [DATA_W-1:0] enq_data_i;
  logic              commit_valid_i;
  logic [ID_W-1:0]   commit_id_i;
  logic              commit_kill_i;
  logic              deq_valid_o;
  logic              deq_ready_i;
  logic [ID_W-1:0]   deq_id_o;
  logic [DATA_W-1:0] deq_data_o;
  logic [CNT_W-1:0]  count_o;

  modport master (
    output enq_valid_i, enq_id_i, enq_committed_i, enq_data_i,
    output commit_valid_i, commit_id_i, commit_kill_i, deq_ready_i,
    input  enq_ready_o, deq_valid_o, deq_id_o, deq_data_o, count_o
  );

  modport slave (
    input  enq_valid_i, enq_id_i, enq_committed_i, enq_data_i,
    input  commit_valid_i, commit_id_i, commit_kill_i, deq_ready_i,
    output enq_ready_o, deq_valid_o, deq_id_o, deq_data_o, count_o
  );
endinterface

// File: rtl/vproc_spec_queue.sv
// In-order instruction queue with per-entry speculation state; committed heads dequeue after >=1 cycle,
// killed heads drop one per cycle, speculative heads stall; enq_ready is !full with no pop bypass.
module vproc_spec_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 3
) (
  input  logic                clk_i,
  input  logic                sync_rst_i,
  vproc_spec_queue_if.slave   q
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_INVALID     = 2'd0,
    ST_SPECULATIVE = 2'd1,
    ST_COMMITTED   = 2'd2,
    ST_KILLED      = 2'd3
  } instr_state_t;

  instr_state_t      state_q [DEPTH];
  logic [ID_W-1:0]   id_q    [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;

  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              full, empty;
  instr_state_t      head_state;
  logic              head_valid, head_killed;
  logic              push, pop;
  instr_state_t      enq_state;

  assign wr_idx      = wr_ptr_q[IDX_W-1:0];
  assign rd_idx      = rd_ptr_q[IDX_W-1:0];
  assign full        = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) && (wr_idx == rd_idx);
  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign head_state  = state_q[rd_idx];
  assign head_valid  = !empty && (head_state == ST_COMMITTED);
  assign head_killed = !empty && (head_state == ST_KILLED);

  assign push = q.enq_valid_i && !full;
  assign pop  = (head_valid && q.deq_ready_i) || head_killed;

  // A resolution arriving alongside its own enqueue is folded into the written state.
  always_comb begin
    enq_state = q.enq_committed_i ? ST_COMMITTED : ST_SPECULATIVE;
    if (!q.enq_committed_i && q.commit_valid_i && (q.commit_id_i == q.enq_id_i)) begin
      enq_state = q.commit_kill_i ? ST_KILLED : ST_COMMITTED;
    end
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= ST_INVALID;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q.commit_valid_i && (state_q[i] == ST_SPECULATIVE) && (id_q[i] == q.commit_id_i)) begin
          state_q[i] <= q.commit_kill_i ? ST_KILLED : ST_COMMITTED;
        end
      end
      // The popped head is never speculative, so this cannot collide with a resolution above.
      if (pop) begin
        state_q[rd_idx] <= ST_INVALID;
        rd_ptr_q        <= rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
        state_q[wr_idx] <= enq_state;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      id_q[wr_idx]   <= q.enq_id_i;
      data_q[wr_idx] <= q.enq_data_i;
    end
  end

  assign q.enq_ready_o = !full;
  assign q.count_o     = wr_ptr_q - rd_ptr_q;
  assign q.deq_valid_o = head_valid;
  assign q.deq_id_o    = id_q[rd_idx];
  assign q.deq_data_o  = data_q[rd_idx];

endmodule
